// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage RV32 pipeline: E-stage forwarding, load-use stall,
// taken-branch flush, multi-cycle execute stall FSM and a saturating stall counter.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int MC_STALL = 3,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    input  logic [REG_AW-1:0]   RD_M,
    input  logic [REG_AW-1:0]   RD_W,
    input  logic [REG_AW-1:0]   RD_E,
    input  logic [REG_AW-1:0]   RS1_E,
    input  logic [REG_AW-1:0]   RS2_E,
    input  logic [REG_AW-1:0]   RS1_D,
    input  logic [REG_AW-1:0]   RS2_D,
    input  logic                LoadE,
    input  logic                MultiCycE,
    input  logic                PCSrcE,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                StallF,
    output logic                StallD,
    output logic                StallE,
    output logic                FlushD,
    output logic                FlushE,
    output logic                FlushM,
    output logic                McBusy,
    output logic [STALL_CW-1:0] StallCount
);

    localparam int CW = $clog2(MC_STALL + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mc_stall;
    logic          lw;

    function automatic logic [1:0] fwd_sel(
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w,
        input logic [REG_AW-1:0] rs
    );
        if (wr_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        mc_stall = 1'b0;
        unique case (state)
            IDLE:    mc_stall = MultiCycE;
            BUSY:    mc_stall = 1'b1;
            default: mc_stall = 1'b0;
        endcase
    end

    assign lw = LoadE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

    // Priority: multi-cycle hold, then branch flush, then load-use bubble.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(RegWriteM, RD_M, RegWriteW, RD_W, RS1_E);
            ForwardBE = fwd_sel(RegWriteM, RD_M, RegWriteW, RD_W, RS2_E);
            if (mc_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign McBusy = (state == BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            StallCount <= '0;
        end else begin
            if (StallF && (StallCount != '1))
                StallCount <= StallCount + STALL_CW'(1);
            unique case (state)
                IDLE: begin
                    if (MultiCycE) begin
                        cnt   <= CW'(MC_STALL - 1);
                        state <= (MC_STALL == 1) ? RELEASE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= RELEASE;
                end
                // The op that stalled is now leaving E; its MultiCycE is not a new request.
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (MC_STALL=3, MC_STALL=1, 4-bit counter)
// driven in parallel and compared every cycle against a remaining-cycles reference model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       RegWriteM, RegWriteW, LoadE, MultiCycE, PCSrcE;
    logic [4:0] RD_M, RD_W, RD_E, RS1_E, RS2_E, RS1_D, RS2_D;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb, c_fa, c_fb;
    logic        a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_mb;
    logic        b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_mb;
    logic        c_sf, c_sd, c_se, c_fd, c_fe, c_fm, c_mb;
    logic [15:0] a_sc, b_sc;
    logic [3:0]  c_sc;

    int errors = 0;
    int checks = 0;

    // Reference state per instance: stall cycles still owed, release pending, counter.
    int mc_len [3] = '{3, 1, 3};
    int cnt_max[3] = '{65535, 65535, 15};
    int left   [3] = '{0, 0, 0};
    bit rel    [3] = '{0, 0, 0};
    int cnt    [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .MC_STALL(3), .STALL_CW(16)) dut_a (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .LoadE(LoadE), .MultiCycE(MultiCycE), .PCSrcE(PCSrcE),
        .ForwardAE(a_fa), .ForwardBE(a_fb), .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
        .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .McBusy(a_mb), .StallCount(a_sc));

    hazard_ctrl_unit #(.REG_AW(5), .MC_STALL(1), .STALL_CW(16)) dut_b (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .LoadE(LoadE), .MultiCycE(MultiCycE), .PCSrcE(PCSrcE),
        .ForwardAE(b_fa), .ForwardBE(b_fb), .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
        .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .McBusy(b_mb), .StallCount(b_sc));

    hazard_ctrl_unit #(.REG_AW(5), .MC_STALL(3), .STALL_CW(4)) dut_c (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .LoadE(LoadE), .MultiCycE(MultiCycE), .PCSrcE(PCSrcE),
        .ForwardAE(c_fa), .ForwardBE(c_fb), .StallF(c_sf), .StallD(c_sd), .StallE(c_se),
        .FlushD(c_fd), .FlushE(c_fe), .FlushM(c_fm), .McBusy(c_mb), .StallCount(c_sc));

    function automatic int ref_fwd(input logic [4:0] rs);
        if (rst) return 0;
        if (RegWriteM && RD_M != 0 && RD_M == rs) return 2;
        if (RegWriteW && RD_W != 0 && RD_W == rs) return 1;
        return 0;
    endfunction

    function automatic bit ref_mc(input int k);
        return !rst && (left[k] > 0 || (!rel[k] && MultiCycE));
    endfunction

    function automatic bit ref_lw();
        return !rst && LoadE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
    endfunction

    function automatic bit ref_stallf(input int k);
        return ref_mc(k) || (!rst && !PCSrcE && ref_lw());
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic sd, input logic se, input logic fd,
                              input logic fe, input logic fm, input logic mb, input logic [15:0] sc);
        bit mc, br, lw;
        mc = ref_mc(k);
        br = !rst && PCSrcE && !mc;
        lw = ref_lw() && !mc && !br;
        chk("ForwardAE", k, 32'(fa), 32'(ref_fwd(RS1_E)));
        chk("ForwardBE", k, 32'(fb), 32'(ref_fwd(RS2_E)));
        chk("StallF", k, 32'(sf), 32'(mc || lw));
        chk("StallD", k, 32'(sd), 32'(mc || lw));
        chk("StallE", k, 32'(se), 32'(mc));
        chk("FlushD", k, 32'(fd), 32'(br));
        chk("FlushE", k, 32'(fe), 32'(br || lw));
        chk("FlushM", k, 32'(fm), 32'(mc));
        chk("McBusy", k, 32'(mb), 32'(left[k] > 0));
        chk("StallCount", k, 32'(sc), 32'(cnt[k]));
    endtask

    task automatic update_models();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                left[k] = 0;
                rel[k]  = 0;
                cnt[k]  = 0;
            end else begin
                if (ref_stallf(k) && cnt[k] < cnt_max[k]) cnt[k]++;
                if (rel[k]) begin
                    rel[k] = 0;
                end else if (left[k] > 0) begin
                    left[k]--;
                    if (left[k] == 0) rel[k] = 1;
                end else if (MultiCycE) begin
                    left[k] = mc_len[k] - 1;
                    if (left[k] == 0) rel[k] = 1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_inst(0, a_fa, a_fb, a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_mb, a_sc);
        check_inst(1, b_fa, b_fb, b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_mb, b_sc);
        check_inst(2, c_fa, c_fb, c_sf, c_sd, c_se, c_fd, c_fe, c_fm, c_mb, {12'd0, c_sc});
        @(posedge clk);
        update_models();
        #1;
    endtask

    task automatic idle_inputs();
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; MultiCycE = 0; PCSrcE = 0;
        RD_M = 0; RD_W = 0; RD_E = 0; RS1_E = 0; RS2_E = 0; RS1_D = 0; RS2_D = 0;
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Reset, with hazard-looking inputs that must be masked.
        idle_inputs();
        rst = 1;
        RegWriteM = 1; RD_M = 5; RS1_E = 5; MultiCycE = 1; PCSrcE = 1;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 0;
        idle_inputs();
        cycle();

        // Forwarding: M match, W-only match, x0 never forwards.
        RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; RS1_E = 5; RS2_E = 5;
        cycle();
        RD_M = 6;
        cycle();
        RD_M = 0; RD_W = 0; RS1_E = 0; RS2_E = 0;
        cycle();
        RD_M = 3; RD_W = 4; RS1_E = 4; RS2_E = 3;
        cycle();
        idle_inputs();

        // Load-use for one cycle, then quiet.
        LoadE = 1; RD_E = 7; RS2_D = 7;
        cycle();
        idle_inputs();
        cycle();

        // Branch together with load-use: branch wins.
        LoadE = 1; RD_E = 7; RS1_D = 7; PCSrcE = 1;
        cycle();
        idle_inputs();
        cycle();

        // Multi-cycle op held high, back-to-back acceptance; forwarding kept live.
        MultiCycE = 1; RegWriteW = 1; RD_W = 9; RS1_E = 9;
        repeat (9) cycle();
        idle_inputs();
        repeat (2) cycle();

        // Reset in the middle of BUSY.
        MultiCycE = 1;
        cycle();
        MultiCycE = 0;
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        repeat (3) cycle();

        // Long multi-cycle run saturates the 4-bit counter.
        MultiCycE = 1;
        repeat (40) cycle();
        idle_inputs();
        repeat (2) cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            RD_M      = 5'($urandom_range(0, 7));
            RD_W      = 5'($urandom_range(0, 7));
            RD_E      = 5'($urandom_range(0, 7));
            RS1_E     = 5'($urandom_range(0, 7));
            RS2_E     = 5'($urandom_range(0, 7));
            RS1_D     = 5'($urandom_range(0, 7));
            RS2_D     = 5'($urandom_range(0, 7));
            LoadE     = 1'($urandom_range(0, 1));
            MultiCycE = ($urandom_range(0, 3) == 0);
            PCSrcE    = ($urandom_range(0, 7) == 0);
            cycle();
        end
        rst = 0;
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
